// File: rtl/vga_arb_pkg.sv
// vga_arb_pkg: shared constants and types for the VGA pixel arbiter.
//   SCREEN_W / SCREEN_H : visible raster size in pixels
//   X_W / Y_W / COLOR_W : coordinate and RGB333 color widths
//   arb_state_t         : arbiter FSM states
package vga_arb_pkg;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;
  localparam int X_W      = 10;
  localparam int Y_W      = 9;
  localparam int COLOR_W  = 9;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    CLEAR = 2'd2
  } arb_state_t;

endpackage

// File: rtl/vga_clear_sweeper.sv
// vga_clear_sweeper: raster counter for a full-screen clear.
//   clk, srst : clock and synchronous active-high reset
//   start     : begin a sweep at (0,0); ignored while busy
//   busy      : a sweep is in progress; x/y are valid
//   x, y      : current pixel, x fastest, rows top to bottom
//   last      : current pixel is (SCREEN_W-1, SCREEN_H-1); the sweep ends after it
module vga_clear_sweeper
  import vga_arb_pkg::*;
(
  input  logic           clk,
  input  logic           srst,
  input  logic           start,
  output logic           busy,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y,
  output logic           last
);

  logic           busy_reg;
  logic [X_W-1:0] x_reg;
  logic [Y_W-1:0] y_reg;
  logic           row_end;

  assign row_end = (x_reg == X_W'(SCREEN_W - 1));
  assign last    = busy_reg && row_end && (y_reg == Y_W'(SCREEN_H - 1));
  assign busy    = busy_reg;
  assign x       = x_reg;
  assign y       = y_reg;

  always_ff @(posedge clk) begin
    if (srst) begin
      busy_reg <= 1'b0;
      x_reg    <= '0;
      y_reg    <= '0;
    end else if (start && !busy_reg) begin
      busy_reg <= 1'b1;
      x_reg    <= '0;
      y_reg    <= '0;
    end else if (busy_reg) begin
      if (last) begin
        busy_reg <= 1'b0;
        x_reg    <= '0;
        y_reg    <= '0;
      end else if (row_end) begin
        x_reg <= '0;
        y_reg <= y_reg + 1'b1;
      end else begin
        x_reg <= x_reg + 1'b1;
      end
    end
  end

endmodule

// File: rtl/vga_pixel_arbiter.sv
// vga_pixel_arbiter: round-robin burst arbiter in front of the vga_adapter
// pixel-write port, with an optional full-screen clear sequencer.
//   CLOCK_50, reset        : clock and synchronous active-high reset
//   req/last               : per-requester pixel valid / final pixel of burst
//   px_x/px_y/px_color     : packed per-requester pixel data (slot i at i*width)
//   gnt                    : registered one-hot grant
//   clear_start/color/busy : full-screen clear control
//   vga_x/y/color/write    : registered pixel to the adapter
//   drop_count             : saturating count of off-screen pixels discarded
// Build option: define VGA_PIXEL_ARB_CLEAR_EN to include the clear sequencer;
// otherwise the clear inputs are ignored and clear_busy is tied low.
module vga_pixel_arbiter
  import vga_arb_pkg::*;
#(
  parameter int NUM_REQ       = 3,
  parameter int BURST_TIMEOUT = 1023
) (
  input  logic                     CLOCK_50,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ-1:0]       last,
  input  logic [NUM_REQ*X_W-1:0]   px_x,
  input  logic [NUM_REQ*Y_W-1:0]   px_y,
  input  logic [NUM_REQ*COLOR_W-1:0] px_color,
  output logic [NUM_REQ-1:0]       gnt,
  input  logic                     clear_start,
  input  logic [COLOR_W-1:0]       clear_color,
  output logic                     clear_busy,
  output logic [X_W-1:0]           vga_x,
  output logic [Y_W-1:0]           vga_y,
  output logic [COLOR_W-1:0]       vga_color,
  output logic                     vga_write,
  output logic [15:0]              drop_count
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int TO_W  = $clog2(BURST_TIMEOUT + 1);

  logic [X_W-1:0]     req_x     [NUM_REQ];
  logic [Y_W-1:0]     req_y     [NUM_REQ];
  logic [COLOR_W-1:0] req_color [NUM_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign req_x[gi]     = px_x[gi*X_W +: X_W];
      assign req_y[gi]     = px_y[gi*Y_W +: Y_W];
      assign req_color[gi] = px_color[gi*COLOR_W +: COLOR_W];
    end
  endgenerate

  arb_state_t         state_reg, state_next;
  logic [NUM_REQ-1:0] gnt_reg, gnt_next;
  logic [IDX_W-1:0]   cur_reg, cur_next;
  logic [IDX_W-1:0]   last_winner_reg, last_winner_next;
  logic [TO_W-1:0]    to_cnt_reg, to_cnt_next;
  logic [X_W-1:0]     x_reg, x_next;
  logic [Y_W-1:0]     y_reg, y_next;
  logic [COLOR_W-1:0] color_reg, color_next;
  logic               write_reg, write_next;
  logic [15:0]        drop_reg, drop_next;

  // Round-robin pick: first requester at or after last_winner+1, wrapping.
  logic             pick_found;
  logic [IDX_W-1:0] pick_idx;
  logic [IDX_W-1:0] cand_idx;
  int               cand;

  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = 0;
    cand_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = int'(last_winner_reg) + 1 + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      cand_idx = IDX_W'(cand);
      if (!pick_found && req[cand_idx]) begin
        pick_found = 1'b1;
        pick_idx   = cand_idx;
      end
    end
  end

  logic xfer;
  logic on_screen;
  assign xfer      = (state_reg == BURST) && req[cur_reg] && gnt_reg[cur_reg];
  assign on_screen = (req_x[cur_reg] < X_W'(SCREEN_W)) && (req_y[cur_reg] < Y_W'(SCREEN_H));

  logic clear_req;
  logic sweep_start;

`ifdef VGA_PIXEL_ARB_CLEAR_EN
  logic               clear_pending_reg, clear_pending_next;
  logic               clear_busy_reg, clear_busy_next;
  logic [COLOR_W-1:0] clear_color_reg, clear_color_next;
  logic               clear_accept;
  logic               sweep_busy;
  logic               sweep_last;
  logic [X_W-1:0]     sweep_x;
  logic [Y_W-1:0]     sweep_y;

  // A start arriving in IDLE counts immediately so it beats a same-cycle req.
  assign clear_accept = clear_start && !clear_busy_reg;
  assign clear_req    = clear_pending_reg || clear_accept;
  assign clear_busy   = clear_busy_reg;

  vga_clear_sweeper u_sweeper (
    .clk   (CLOCK_50),
    .srst  (reset),
    .start (sweep_start),
    .busy  (sweep_busy),
    .x     (sweep_x),
    .y     (sweep_y),
    .last  (sweep_last)
  );

  always_comb begin
    clear_pending_next = clear_pending_reg || clear_accept;
    clear_busy_next    = clear_busy_reg || clear_accept;
    clear_color_next   = clear_accept ? clear_color : clear_color_reg;
    if (sweep_start) clear_pending_next = 1'b0;
    // Busy drops together with the final pixel's write strobe.
    if (sweep_last) clear_busy_next = 1'b0;
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      clear_pending_reg <= 1'b0;
      clear_busy_reg    <= 1'b0;
      clear_color_reg   <= '0;
    end else begin
      clear_pending_reg <= clear_pending_next;
      clear_busy_reg    <= clear_busy_next;
      clear_color_reg   <= clear_color_next;
    end
  end
`else
  logic unused_clear;
  assign unused_clear = ^{clear_start, clear_color};
  assign clear_req    = 1'b0;
  assign clear_busy   = 1'b0;
`endif

  always_comb begin
    state_next       = state_reg;
    gnt_next         = gnt_reg;
    cur_next         = cur_reg;
    last_winner_next = last_winner_reg;
    to_cnt_next      = to_cnt_reg;
    x_next           = x_reg;
    y_next           = y_reg;
    color_next       = color_reg;
    write_next       = 1'b0;
    drop_next        = drop_reg;
    sweep_start      = 1'b0;
    case (state_reg)
      IDLE: begin
        to_cnt_next = '0;
        if (clear_req) begin
          state_next  = CLEAR;
          sweep_start = 1'b1;
        end else if (pick_found) begin
          state_next         = BURST;
          cur_next           = pick_idx;
          gnt_next           = '0;
          gnt_next[pick_idx] = 1'b1;
        end
      end
      BURST: begin
        if (xfer) begin
          to_cnt_next = '0;
          x_next      = req_x[cur_reg];
          y_next      = req_y[cur_reg];
          color_next  = req_color[cur_reg];
          if (on_screen) write_next = 1'b1;
          else if (drop_reg != 16'hFFFF) drop_next = drop_reg + 16'd1;
          if (last[cur_reg]) begin
            state_next       = IDLE;
            gnt_next         = '0;
            last_winner_next = cur_reg;
          end
        end else if (to_cnt_reg == TO_W'(BURST_TIMEOUT - 1)) begin
          // Stalled requester: give up so the others are not starved.
          state_next       = IDLE;
          gnt_next         = '0;
          last_winner_next = cur_reg;
          to_cnt_next      = '0;
        end else begin
          to_cnt_next = to_cnt_reg + 1'b1;
        end
      end
`ifdef VGA_PIXEL_ARB_CLEAR_EN
      CLEAR: begin
        write_next = sweep_busy;
        x_next     = sweep_x;
        y_next     = sweep_y;
        color_next = clear_color_reg;
        if (sweep_last) state_next = IDLE;
      end
`endif
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_reg       <= IDLE;
      gnt_reg         <= '0;
      cur_reg         <= '0;
      last_winner_reg <= IDX_W'(NUM_REQ - 1);
      to_cnt_reg      <= '0;
      x_reg           <= '0;
      y_reg           <= '0;
      color_reg       <= '0;
      write_reg       <= 1'b0;
      drop_reg        <= '0;
    end else begin
      state_reg       <= state_next;
      gnt_reg         <= gnt_next;
      cur_reg         <= cur_next;
      last_winner_reg <= last_winner_next;
      to_cnt_reg      <= to_cnt_next;
      x_reg           <= x_next;
      y_reg           <= y_next;
      color_reg       <= color_next;
      write_reg       <= write_next;
      drop_reg        <= drop_next;
    end
  end

  assign gnt        = gnt_reg;
  assign vga_x      = x_reg;
  assign vga_y      = y_reg;
  assign vga_color  = color_reg;
  assign vga_write  = write_reg;
  assign drop_count = drop_reg;

endmodule

// File: tb/tb_vga_pixel_arbiter.sv
// tb_vga_pixel_arbiter: directed self-checking bench for vga_pixel_arbiter.
// Clear-sequencer steps run only when VGA_PIXEL_ARB_CLEAR_EN is defined.
module tb_vga_pixel_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  req, last, gnt;
  logic [29:0] px_x;
  logic [26:0] px_y, px_color;
  logic        clear_start, clear_busy, vga_write;
  logic [8:0]  clear_color, vga_y, vga_color;
  logic [9:0]  vga_x;
  logic [15:0] drop_count;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  vga_pixel_arbiter #(.NUM_REQ(3), .BURST_TIMEOUT(1023)) dut (
    .CLOCK_50    (clk),
    .reset       (reset),
    .req         (req),
    .last        (last),
    .px_x        (px_x),
    .px_y        (px_y),
    .px_color    (px_color),
    .gnt         (gnt),
    .clear_start (clear_start),
    .clear_color (clear_color),
    .clear_busy  (clear_busy),
    .vga_x       (vga_x),
    .vga_y       (vga_y),
    .vga_color   (vga_color),
    .vga_write   (vga_write),
    .drop_count  (drop_count)
  );

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    assert (observed === expected) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_px(input int i, input int x, input int y, input int c);
    px_x[i*10 +: 10]    = 10'(x);
    px_y[i*9 +: 9]      = 9'(y);
    px_color[i*9 +: 9]  = 9'(c);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [2:0] rr_exp [7];
  int n, ex, ey, lx, ly, raster_err, color_err, busy_err;
  bit pulsed;

  initial begin
    reset = 1'b1; req = '0; last = '0; px_x = '0; px_y = '0; px_color = '0;
    clear_start = 1'b0; clear_color = '0;
    rr_exp = '{3'b001, 3'b000, 3'b010, 3'b000, 3'b100, 3'b000, 3'b001};

    // Reset values
    do_reset();
    check("rst_gnt", gnt, 0);
    check("rst_write", vga_write, 0);
    check("rst_x", vga_x, 0);
    check("rst_y", vga_y, 0);
    check("rst_color", vga_color, 0);
    check("rst_clear_busy", clear_busy, 0);
    check("rst_drop", drop_count, 0);

    // Requester 1: 4-pixel burst at (10..13,20), color 1C0
    set_px(1, 10, 20, 9'h1C0); req = 3'b010; last = 3'b000;
    tick();
    check("b1_gnt", gnt, 3'b010);
    check("b1_nowrite", vga_write, 0);
    for (int p = 0; p < 4; p++) begin
      set_px(1, 10 + p, 20, 9'h1C0);
      last = (p == 3) ? 3'b010 : 3'b000;
      tick();
      $display("burst1 pixel %0d: write=%0d x=%0d y=%0d color=%0h gnt=%b", p, vga_write, vga_x, vga_y, vga_color, gnt);
      check("b1_write", vga_write, 1);
      check("b1_x", vga_x, 10 + p);
      check("b1_y", vga_y, 20);
      check("b1_color", vga_color, 9'h1C0);
    end
    check("b1_gnt_clear", gnt, 0);
    req = '0; last = '0;
    tick();
    check("b1_idle_write", vga_write, 0);

    // Round robin from reset: 0,1,2,0 with one bubble between bursts
    do_reset();
    set_px(0, 1, 1, 1); set_px(1, 2, 2, 2); set_px(2, 3, 3, 3);
    req = 3'b111; last = 3'b111;
    for (int s = 0; s < 7; s++) begin
      tick();
      $display("rr step %0d: gnt=%b", s, gnt);
      check("rr_gnt", gnt, rr_exp[s]);
    end
    req = 3'b001;
    tick();
    check("rr_final_gnt", gnt, 0);

    // Off-screen pixel from requester 0, then a normal last pixel
    set_px(0, 700, 5, 9'h0AA); req = 3'b001; last = 3'b000;
    tick();
    check("oob_gnt", gnt, 3'b001);
    tick();
    $display("oob pixel: write=%0d drop=%0d", vga_write, drop_count);
    check("oob_nowrite", vga_write, 0);
    check("oob_drop", drop_count, 1);
    set_px(0, 5, 5, 9'h0AA); last = 3'b001;
    tick();
    check("oob_last_write", vga_write, 1);
    check("oob_last_x", vga_x, 5);
    check("oob_last_gnt", gnt, 0);
    check("oob_drop_hold", drop_count, 1);
    req = '0; last = '0;

    // Requester 2 granted then stalls; requester 0 waits
    set_px(2, 1, 1, 9'h111); req = 3'b100;
    tick();
    check("to_gnt2", gnt, 3'b100);
    set_px(0, 3, 4, 9'h0F0); req = 3'b001; last = 3'b001;
    repeat (1022) tick();
    check("to_hold", gnt, 3'b100);
    check("to_nowrite", vga_write, 0);
    tick();
    $display("timeout: gnt=%b after 1023 stall cycles", gnt);
    check("to_abort", gnt, 0);
    tick();
    check("to_next_gnt0", gnt, 3'b001);
    tick();
    check("to_r0_write", vga_write, 1);
    check("to_r0_x", vga_x, 3);
    check("to_r0_y", vga_y, 4);
    req = '0; last = '0;

    // Reset mid-burst
    set_px(1, 50, 60, 9'h055); req = 3'b010;
    tick();
    check("rb_gnt", gnt, 3'b010);
    tick();
    check("rb_write", vga_write, 1);
    reset = 1'b1;
    tick();
    check("rb_gnt_rst", gnt, 0);
    check("rb_write_rst", vga_write, 0);
    check("rb_x_rst", vga_x, 0);
    check("rb_color_rst", vga_color, 0);
    check("rb_drop_rst", drop_count, 0);
    reset = 1'b0; req = '0;
    tick();

`ifdef VGA_PIXEL_ARB_CLEAR_EN
    // Clear requested during a requester-0 burst
    do_reset();
    set_px(0, 7, 7, 9'h1FF); req = 3'b001; last = 3'b000;
    tick();
    check("cl_gnt0", gnt, 3'b001);
    clear_start = 1'b1; clear_color = 9'h007;
    tick();
    clear_start = 1'b0; clear_color = 9'h000;
    check("cl_busy_set", clear_busy, 1);
    check("cl_burst_write", vga_write, 1);
    last = 3'b001;
    tick();
    check("cl_burst_last_write", vga_write, 1);
    check("cl_burst_gnt_clear", gnt, 0);
    req = '0; last = '0;
    n = 0; ex = 0; ey = 0; lx = -1; ly = -1;
    raster_err = 0; color_err = 0; busy_err = 0; pulsed = 0;
    for (int cyc = 0; cyc < 310000 && n < 307200; cyc++) begin
      if (n == 500 && !pulsed) begin
        clear_start = 1'b1; clear_color = 9'h1FF; pulsed = 1;
      end
      tick();
      clear_start = 1'b0;
      if (vga_write) begin
        if (vga_x !== 10'(ex) || vga_y !== 9'(ey)) raster_err++;
        if (vga_color !== 9'h007) color_err++;
        n++;
        if (clear_busy !== (n < 307200)) busy_err++;
        lx = int'(vga_x); ly = int'(vga_y);
        if (ex == 639) begin ex = 0; ey++; end else ex++;
      end
    end
    $display("clear: writes=%0d last=(%0d,%0d) raster_err=%0d color_err=%0d busy_err=%0d", n, lx, ly, raster_err, color_err, busy_err);
    check("cl_writes", n, 307200);
    check("cl_raster", raster_err, 0);
    check("cl_color", color_err, 0);
    check("cl_busy_track", busy_err, 0);
    check("cl_last_x", lx, 639);
    check("cl_last_y", ly, 479);
    tick();
    check("cl_done_write", vga_write, 0);
    check("cl_done_busy", clear_busy, 0);

    // Reset at clear pixel 1000
    clear_start = 1'b1; clear_color = 9'h0AA;
    tick();
    clear_start = 1'b0;
    n = 0;
    for (int cyc = 0; cyc < 2000 && n < 1000; cyc++) begin
      tick();
      if (vga_write) n++;
    end
    check("cr_reached", n, 1000);
    reset = 1'b1;
    tick();
    $display("reset mid-clear: write=%0d busy=%0d gnt=%b", vga_write, clear_busy, gnt);
    check("cr_write", vga_write, 0);
    check("cr_busy", clear_busy, 0);
    check("cr_gnt", gnt, 0);
    reset = 1'b0;
    set_px(0, 9, 9, 9'h123); req = 3'b001; last = 3'b001;
    tick();
    check("cr_idle_gnt", gnt, 3'b001);
    tick();
    check("cr_idle_write", vga_write, 1);
    check("cr_idle_x", vga_x, 9);
    req = '0; last = '0;
`else
    // Clear disabled: start is ignored
    clear_start = 1'b1; clear_color = 9'h1FF;
    tick();
    clear_start = 1'b0;
    check("nc_busy", clear_busy, 0);
    tick();
    tick();
    $display("clear disabled: write=%0d busy=%0d gnt=%b", vga_write, clear_busy, gnt);
    check("nc_write", vga_write, 0);
    check("nc_gnt", gnt, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
